fpu_issue_queue: RTL and testbench
==================================

Name: fpu_issue_queue

Overview:
- In-order issue queue feeding the FPU execution unit.
- Buffers renamed FP micro-ops from dispatch and holds the head entry until its physical source registers are ready in the scoreboard.
- Drives the FPU's start/opcode/pointer issue interface with one registered issue per cycle.
- Tracks ops in flight inside the FPU pipeline so the core can detect FPU drain.

Parameters:
- LG_PRF_WIDTH, 4, log2 of physical register count.
- LG_ROB_WIDTH, 4, log2 of ROB entries.
- LG_FCR_WIDTH, 4, log2 of FCR rename entries.
- LG_FIQ_DEPTH, 2, log2 of queue depth (DEPTH = 2**LG_FIQ_DEPTH).
- FPU_LAT, 2, fixed FPU latency from start to result valid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- flush  in  1  discard all queued entries
- enq_val  in  1  dispatch offers an op
- enq_rdy  out  1  queue accepts op (enq_val & enq_rdy = enqueue)
- enq_opcode  in  opcode_t  FP opcode
- enq_srca, enq_srcb, enq_srcc  in  LG_PRF_WIDTH each  source physical pointers
- enq_use_c  in  1  srcc is a real operand
- enq_rob  in  LG_ROB_WIDTH  ROB pointer
- enq_dst  in  LG_PRF_WIDTH  destination pointer
- enq_fcr  in  LG_FCR_WIDTH  FCR rename pointer
- enq_fcr_sel  in  3  FCR condition-bit select
- prf_ready  in  2**LG_PRF_WIDTH  scoreboard ready bit per physical register
- issue_block  in  1  writeback port unavailable; hold issue
- start  out  1  one-cycle issue strobe to the FPU
- opcode  out  opcode_t  issued opcode
- srca_ptr, srcb_ptr, srcc_ptr  out  LG_PRF_WIDTH each  issued source pointers (to PRF read)
- rob_ptr_out  out  LG_ROB_WIDTH  issued ROB pointer
- dst_ptr_out  out  LG_PRF_WIDTH  issued destination pointer
- fcr_ptr_out  out  LG_FCR_WIDTH  issued FCR pointer
- fcr_sel_out  out  3  issued FCR select
- count  out  LG_FIQ_DEPTH+1  occupied entries
- fpu_idle  out  1  queue empty and nothing in flight

Behaviour:
- Storage: circular buffer with DEPTH entries, head and tail pointers of LG_FIQ_DEPTH bits, both wrapping modulo DEPTH. The count register ranges 0..DEPTH.
- Enqueue:
  - enq_rdy = (count != DEPTH), computed from registered count only.
  - When full, a same-cycle dequeue does not open a slot; enq_rdy stays 0 that cycle.
  - On enqueue the entry is written at tail, tail increments and count increments.
- Issue decision (combinational, cycle t): issue when all of the following hold:
  - count != 0
  - !issue_block
  - !flush
  - prf_ready[srca] & prf_ready[srcb] & (!use_c | prf_ready[srcc]) for the head entry
- Ordering: an entry enqueued in cycle t cannot issue before cycle t+1.
- Issue output:
  - All issue outputs are registered. At cycle t+1, start=1 and the output fields carry the head entry.
  - Head increments and count decrements at the t edge.
  - start is never high on two consecutive cycles for the same entry. Back-to-back issue of different entries is allowed (1 per cycle).
  - When start=0 the output fields hold their last values (don't-care).
- Simultaneous enqueue and issue: count is unchanged, both pointers advance.
- Flush:
  - At the next edge, head=tail=0, count=0 and start=0.
  - An enqueue presented in the flush cycle is dropped.
  - An issue registered in the cycle before flush still appears. Flush does not cancel it.
- In-flight tracking:
  - FPU_LAT-bit shift register. Bit FPU_LAT-1 loads start; the register shifts down each cycle.
  - Flush does not clear it, because the FPU completes ops regardless.
  - fpu_idle = (count==0) & (start==0) & (shift register == 0).
- Reset (reset==0 at an edge):
  - head=tail=count=0, start=0, shift register=0.
  - Resulting outputs: enq_rdy=1, fpu_idle=1, all pointer outputs 0.
  - Reset has priority over flush, enqueue and issue. Reset mid-stream discards all entries.
- Head stalling on unready sources blocks younger entries (strict in-order).

Test Plan:
- Reset then enqueue 1 op (srca=3, srcb=4, use_c=0, rob=5, dst=9) with prf_ready[3]=prf_ready[4]=1 -> start=1 two cycles after enq_val, rob_ptr_out=5, dst_ptr_out=9; fpu_idle returns to 1 FPU_LAT=2 cycles after start.
- Enqueue 4 ops with prf_ready all 0 -> count=4, enq_rdy=0; a 5th enq_val is held and not accepted; raise all prf_ready -> 4 consecutive start pulses in enqueue order (rob 0,1,2,3), enq_rdy=1 the cycle after the first issue.
- Head uses_c=1 with srcc=7 unready, second entry fully ready -> no start until prf_ready[7]=1, then head issues before the second entry.
- issue_block=1 for 3 cycles with a ready head -> no start during the block; start on the cycle after issue_block drops.
- Queue holding 3 entries, assert flush with a simultaneous enq_val -> count=0 next cycle, the dropped op never issues; an in-flight op keeps fpu_idle=0 for FPU_LAT cycles.
- Drive reset=0 mid-stream with count=2 -> count=0, start=0, fpu_idle=1 after the edge; normal enqueue resumes when reset=1.

Source files
------------

// File: rtl/fpu_issue_queue_if.sv
`default_nettype none
// fpu_issue_queue_if -- dispatch, scoreboard and FPU issue signals of the FP issue queue.
// Rev 1.0
interface fpu_issue_queue_if #(
  parameter int LG_PRF_WIDTH = 4,
  parameter int LG_ROB_WIDTH = 4,
  parameter int LG_FCR_WIDTH = 4,
  parameter int LG_FIQ_DEPTH = 2,
  parameter int OPC_WIDTH    = 6
);
  typedef logic [OPC_WIDTH-1:0] opcode_t;

  // Dispatch side
  logic                          flush;
  logic                          enq_val;
  logic                          enq_rdy;
  opcode_t                       enq_opcode;
  logic [LG_PRF_WIDTH-1:0]       enq_srca;
  logic [LG_PRF_WIDTH-1:0]       enq_srcb;
  logic [LG_PRF_WIDTH-1:0]       enq_srcc;
  logic                          enq_use_c;
  logic [LG_ROB_WIDTH-1:0]       enq_rob;
  logic [LG_PRF_WIDTH-1:0]       enq_dst;
  logic [LG_FCR_WIDTH-1:0]       enq_fcr;
  logic [2:0]                    enq_fcr_sel;

  // Scoreboard / writeback arbitration
  logic [(2**LG_PRF_WIDTH)-1:0]  prf_ready;
  logic                          issue_block;

  // FPU issue side
  logic                          start;
  opcode_t                       opcode;
  logic [LG_PRF_WIDTH-1:0]       srca_ptr;
  logic [LG_PRF_WIDTH-1:0]       srcb_ptr;
  logic [LG_PRF_WIDTH-1:0]       srcc_ptr;
  logic [LG_ROB_WIDTH-1:0]       rob_ptr_out;
  logic [LG_PRF_WIDTH-1:0]       dst_ptr_out;
  logic [LG_FCR_WIDTH-1:0]       fcr_ptr_out;
  logic [2:0]                    fcr_sel_out;
  logic [LG_FIQ_DEPTH:0]         count;
  logic                          fpu_idle;

  modport slave (
    input  flush, enq_val, enq_opcode, enq_srca, enq_srcb, enq_srcc, enq_use_c,
           enq_rob, enq_dst, enq_fcr, enq_fcr_sel, prf_ready, issue_block,
    output enq_rdy, start, opcode, srca_ptr, srcb_ptr, srcc_ptr, rob_ptr_out,
           dst_ptr_out, fcr_ptr_out, fcr_sel_out, count, fpu_idle
  );

  modport master (
    output flush, enq_val, enq_opcode, enq_srca, enq_srcb, enq_srcc, enq_use_c,
           enq_rob, enq_dst, enq_fcr, enq_fcr_sel, prf_ready, issue_block,
    input  enq_rdy, start, opcode, srca_ptr, srcb_ptr, srcc_ptr, rob_ptr_out,
           dst_ptr_out, fcr_ptr_out, fcr_sel_out, count, fpu_idle
  );
endinterface
`default_nettype wire

// File: rtl/fpu_issue_queue.sv
`default_nettype none
// fpu_issue_queue -- in-order FP issue queue: buffers renamed ops, issues the head once its sources are ready.
// Rev 1.0
module fpu_issue_queue #(
  parameter int LG_PRF_WIDTH = 4,
  parameter int LG_ROB_WIDTH = 4,
  parameter int LG_FCR_WIDTH = 4,
  parameter int LG_FIQ_DEPTH = 2,
  parameter int FPU_LAT      = 2,
  parameter int OPC_WIDTH    = 6
) (
  input  logic              clk,
  input  logic              reset,
  fpu_issue_queue_if.slave  bus
);
  localparam int DEPTH = 1 << LG_FIQ_DEPTH;
  localparam int CW    = LG_FIQ_DEPTH + 1;

  localparam logic [CW-1:0]           C_CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]           C_CNT_ONE  = CW'(1);
  localparam logic [LG_FIQ_DEPTH-1:0] C_PTR_ONE  = LG_FIQ_DEPTH'(1);

  typedef struct packed {
    logic [OPC_WIDTH-1:0]    opcode;
    logic [LG_PRF_WIDTH-1:0] srca;
    logic [LG_PRF_WIDTH-1:0] srcb;
    logic [LG_PRF_WIDTH-1:0] srcc;
    logic                    use_c;
    logic [LG_ROB_WIDTH-1:0] rob;
    logic [LG_PRF_WIDTH-1:0] dst;
    logic [LG_FCR_WIDTH-1:0] fcr;
    logic [2:0]              fcr_sel;
  } entry_t;

  typedef struct packed {
    logic [OPC_WIDTH-1:0]    opcode;
    logic [LG_PRF_WIDTH-1:0] srca;
    logic [LG_PRF_WIDTH-1:0] srcb;
    logic [LG_PRF_WIDTH-1:0] srcc;
    logic [LG_ROB_WIDTH-1:0] rob;
    logic [LG_PRF_WIDTH-1:0] dst;
    logic [LG_FCR_WIDTH-1:0] fcr;
    logic [2:0]              fcr_sel;
  } issue_t;

  entry_t                  mem_q [DEPTH];
  entry_t                  mem_d [DEPTH];
  logic [LG_FIQ_DEPTH-1:0] head_q, head_d;
  logic [LG_FIQ_DEPTH-1:0] tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    start_q, start_d;
  issue_t                  out_q, out_d;
  logic [FPU_LAT-1:0]      inflight_q, inflight_d;

  entry_t enq_entry;
  entry_t head_entry;
  logic   enq_rdy;
  logic   enq_fire;
  logic   head_ready;
  logic   issue_go;

  // Full-ness comes from the registered count only, so a same-cycle issue never frees a slot.
  always_comb begin
    enq_entry = '{opcode:  bus.enq_opcode,
                  srca:    bus.enq_srca,
                  srcb:    bus.enq_srcb,
                  srcc:    bus.enq_srcc,
                  use_c:   bus.enq_use_c,
                  rob:     bus.enq_rob,
                  dst:     bus.enq_dst,
                  fcr:     bus.enq_fcr,
                  fcr_sel: bus.enq_fcr_sel};
    head_entry = mem_q[head_q];
    head_ready = bus.prf_ready[head_entry.srca] & bus.prf_ready[head_entry.srcb] &
                 (~head_entry.use_c | bus.prf_ready[head_entry.srcc]);
    enq_rdy    = (count_q != C_CNT_FULL);
    enq_fire   = bus.enq_val & enq_rdy & ~bus.flush;
    issue_go   = (count_q != '0) & ~bus.issue_block & ~bus.flush & head_ready;
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        mem_d[tail_q] = enq_entry;
        tail_d        = tail_q + C_PTR_ONE;
      end
      if (issue_go) begin
        head_d = head_q + C_PTR_ONE;
      end
      case ({enq_fire, issue_go})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Issue fields only change on a real issue; they hold otherwise.
  always_comb begin
    start_d = issue_go;
    out_d   = out_q;
    if (issue_go) begin
      out_d = '{opcode:  head_entry.opcode,
                srca:    head_entry.srca,
                srcb:    head_entry.srcb,
                srcc:    head_entry.srcc,
                rob:     head_entry.rob,
                dst:     head_entry.dst,
                fcr:     head_entry.fcr,
                fcr_sel: head_entry.fcr_sel};
    end
  end

  // In-flight shift register is deliberately untouched by flush: the FPU finishes what it started.
  generate
    if (FPU_LAT > 1) begin : g_inflight_shift
      always_comb begin
        inflight_d = {start_q, inflight_q[FPU_LAT-1:1]};
      end
    end else begin : g_inflight_single
      always_comb begin
        inflight_d = start_q;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      start_q    <= 1'b0;
      out_q      <= '0;
      inflight_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      start_q    <= start_d;
      out_q      <= out_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.enq_rdy     = enq_rdy;
  assign bus.start       = start_q;
  assign bus.opcode      = out_q.opcode;
  assign bus.srca_ptr    = out_q.srca;
  assign bus.srcb_ptr    = out_q.srcb;
  assign bus.srcc_ptr    = out_q.srcc;
  assign bus.rob_ptr_out = out_q.rob;
  assign bus.dst_ptr_out = out_q.dst;
  assign bus.fcr_ptr_out = out_q.fcr;
  assign bus.fcr_sel_out = out_q.fcr_sel;
  assign bus.count       = count_q;
  assign bus.fpu_idle    = (count_q == '0) & ~start_q & (inflight_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_queue.sv
`default_nettype none
// tb_fpu_issue_queue -- directed and randomized checks of fpu_issue_queue against a queue-based model.
// Rev 1.0
module tb_fpu_issue_queue;
  localparam int LG_PRF  = 4;
  localparam int LG_ROB  = 4;
  localparam int LG_FCR  = 4;
  localparam int LG_FIQ  = 2;
  localparam int FPU_LAT = 2;
  localparam int OPC_W   = 6;
  localparam int DEPTH   = 1 << LG_FIQ;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_issue_queue_if #(.LG_PRF_WIDTH(LG_PRF), .LG_ROB_WIDTH(LG_ROB), .LG_FCR_WIDTH(LG_FCR),
                       .LG_FIQ_DEPTH(LG_FIQ), .OPC_WIDTH(OPC_W)) bus ();

  fpu_issue_queue #(.LG_PRF_WIDTH(LG_PRF), .LG_ROB_WIDTH(LG_ROB), .LG_FCR_WIDTH(LG_FCR),
                    .LG_FIQ_DEPTH(LG_FIQ), .FPU_LAT(FPU_LAT), .OPC_WIDTH(OPC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [OPC_W-1:0]  opcode;
    logic [LG_PRF-1:0] srca;
    logic [LG_PRF-1:0] srcb;
    logic [LG_PRF-1:0] srcc;
    logic              use_c;
    logic [LG_ROB-1:0] rob;
    logic [LG_PRF-1:0] dst;
    logic [LG_FCR-1:0] fcr;
    logic [2:0]        fcr_sel;
  } op_t;

  // Reference model: FIFO of ops, last issued op, and the cycles in which start was seen.
  op_t mq[$];
  op_t m_out;
  bit  m_start;
  int  hist[$];
  int  cyc;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t cur_op();
    op_t o;
    o.opcode = bus.enq_opcode; o.srca = bus.enq_srca; o.srcb = bus.enq_srcb;
    o.srcc = bus.enq_srcc; o.use_c = bus.enq_use_c; o.rob = bus.enq_rob;
    o.dst = bus.enq_dst; o.fcr = bus.enq_fcr; o.fcr_sel = bus.enq_fcr_sel;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.opcode = OPC_W'($urandom); o.srca = LG_PRF'($urandom); o.srcb = LG_PRF'($urandom);
    o.srcc = LG_PRF'($urandom); o.use_c = 1'($urandom); o.rob = LG_ROB'($urandom);
    o.dst = LG_PRF'($urandom); o.fcr = LG_FCR'($urandom); o.fcr_sel = 3'($urandom);
    return o;
  endfunction

  function automatic op_t mk_op(int a, int b, int c, bit uc, int rob, int dst);
    op_t o;
    o = rand_op();
    o.srca = LG_PRF'(a); o.srcb = LG_PRF'(b); o.srcc = LG_PRF'(c);
    o.use_c = uc; o.rob = LG_ROB'(rob); o.dst = LG_PRF'(dst);
    return o;
  endfunction

  task automatic drive_op(op_t o);
    bus.enq_opcode = o.opcode; bus.enq_srca = o.srca; bus.enq_srcb = o.srcb;
    bus.enq_srcc = o.srcc; bus.enq_use_c = o.use_c; bus.enq_rob = o.rob;
    bus.enq_dst = o.dst; bus.enq_fcr = o.fcr; bus.enq_fcr_sel = o.fcr_sel;
  endtask

  function automatic bit srcs_ready(op_t o);
    return bus.prf_ready[o.srca] && bus.prf_ready[o.srcb] && (!o.use_c || bus.prf_ready[o.srcc]);
  endfunction

  function automatic logic [63:0] pack_op(op_t o);
    return 64'({o.opcode, o.srca, o.srcb, o.srcc, o.rob, o.dst, o.fcr, o.fcr_sel});
  endfunction

  function automatic bit exp_idle();
    bit busy;
    busy = (mq.size() != 0) || m_start;
    foreach (hist[i]) if (hist[i] >= cyc - FPU_LAT && hist[i] <= cyc - 1) busy = 1'b1;
    return !busy;
  endfunction

  // Advance the model by one clock edge using the inputs presented in the ending cycle.
  task automatic model_step();
    op_t inop;
    bit  go;
    bit  enq;
    if (!reset) begin
      mq.delete();
      hist.delete();
      m_start = 1'b0;
      m_out   = '{default: '0};
    end else begin
      if (m_start) hist.push_back(cyc);
      go   = (mq.size() != 0) && !bus.issue_block && !bus.flush && srcs_ready(mq[0]);
      enq  = bus.enq_val && (mq.size() < DEPTH) && !bus.flush;
      inop = cur_op();
      if (bus.flush) begin
        mq.delete();
        m_start = 1'b0;
      end else begin
        m_start = go;
        if (go) m_out = mq.pop_front();
        if (enq) mq.push_back(inop);
      end
    end
    cyc++;
    while (hist.size() != 0 && hist[0] < cyc - FPU_LAT) void'(hist.pop_front());
  endtask

  task automatic check_all();
    chk("enq_rdy",  64'(bus.enq_rdy),  64'(mq.size() < DEPTH));
    chk("start",    64'(bus.start),    64'(m_start));
    chk("count",    64'(bus.count),    64'(mq.size()));
    chk("fpu_idle", 64'(bus.fpu_idle), 64'(exp_idle()));
    chk("fields",
        64'({bus.opcode, bus.srca_ptr, bus.srcb_ptr, bus.srcc_ptr, bus.rob_ptr_out,
             bus.dst_ptr_out, bus.fcr_ptr_out, bus.fcr_sel_out}),
        pack_op(m_out));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    cyc = 0;
    m_start = 1'b0;
    m_out = '{default: '0};
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.enq_val = 1'b0;
    bus.issue_block = 1'b0;
    bus.prf_ready = '0;
    drive_op(rand_op());

    // Reset state
    cycle();
    cycle();
    chk("rst_enq_rdy", 64'(bus.enq_rdy), 64'd1);
    chk("rst_idle",    64'(bus.fpu_idle), 64'd1);
    chk("rst_rob",     64'(bus.rob_ptr_out), 64'd0);
    reset = 1'b1;

    // Single op: start two cycles after enq_val, idle again FPU_LAT cycles after start
    bus.prf_ready = '0;
    bus.prf_ready[3] = 1'b1;
    bus.prf_ready[4] = 1'b1;
    drive_op(mk_op(3, 4, 0, 1'b0, 5, 9));
    bus.enq_val = 1'b1;
    cycle();
    bus.enq_val = 1'b0;
    cycle();
    chk("t1_start", 64'(bus.start), 64'd1);
    chk("t1_rob",   64'(bus.rob_ptr_out), 64'd5);
    chk("t1_dst",   64'(bus.dst_ptr_out), 64'd9);
    cycle();
    chk("t1_busy1", 64'(bus.fpu_idle), 64'd0);
    cycle();
    chk("t1_busy2", 64'(bus.fpu_idle), 64'd0);
    cycle();
    chk("t1_idle",  64'(bus.fpu_idle), 64'd1);

    // Fill to full with unready sources, fifth op is held
    bus.prf_ready = '0;
    for (int i = 0; i < 4; i++) begin
      drive_op(mk_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     1'($urandom), i, $urandom_range(0, 15)));
      bus.enq_val = 1'b1;
      cycle();
    end
    chk("t2_count", 64'(bus.count), 64'd4);
    chk("t2_full",  64'(bus.enq_rdy), 64'd0);
    drive_op(mk_op(1, 2, 3, 1'b0, 4, 8));
    cycle();
    chk("t2_held", 64'(bus.count), 64'd4);
    bus.prf_ready = '1;
    cycle();
    chk("t2_rob0", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd0}));
    chk("t2_rdy",  64'(bus.enq_rdy), 64'd1);
    cycle();
    bus.enq_val = 1'b0;
    chk("t2_rob1", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd1}));
    cycle();
    chk("t2_rob2", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd2}));
    cycle();
    chk("t2_rob3", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd3}));
    cycle();
    chk("t2_rob4", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd4}));
    repeat (3) cycle();

    // Head waits on srcc while a ready younger op stays behind it
    bus.prf_ready = '1;
    bus.prf_ready[7] = 1'b0;
    drive_op(mk_op(1, 2, 7, 1'b1, 10, 3));
    bus.enq_val = 1'b1;
    cycle();
    drive_op(mk_op(1, 2, 7, 1'b0, 11, 4));
    cycle();
    bus.enq_val = 1'b0;
    repeat (3) begin
      cycle();
      chk("t3_wait", 64'(bus.start), 64'd0);
    end
    bus.prf_ready[7] = 1'b1;
    cycle();
    chk("t3_head", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd10}));
    cycle();
    chk("t3_next", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd11}));
    repeat (3) cycle();

    // issue_block held for three cycles
    bus.issue_block = 1'b1;
    drive_op(mk_op(5, 6, 0, 1'b0, 12, 2));
    bus.enq_val = 1'b1;
    cycle();
    bus.enq_val = 1'b0;
    cycle();
    chk("t4_blk1", 64'(bus.start), 64'd0);
    cycle();
    chk("t4_blk2", 64'(bus.start), 64'd0);
    bus.issue_block = 1'b0;
    cycle();
    chk("t4_go", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd12}));
    repeat (3) cycle();

    // Flush with a queued backlog, an in-flight op and a same-cycle enqueue
    bus.prf_ready = '0;
    for (int i = 0; i < 3; i++) begin
      drive_op(mk_op(i, i + 1, 0, 1'b0, i, 1));
      bus.enq_val = 1'b1;
      cycle();
    end
    bus.enq_val = 1'b0;
    bus.prf_ready = '1;
    cycle();
    chk("t5_issue", 64'(bus.start), 64'd1);
    bus.flush = 1'b1;
    drive_op(mk_op(0, 0, 0, 1'b0, 15, 15));
    bus.enq_val = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bus.enq_val = 1'b0;
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_busy",  64'(bus.fpu_idle), 64'd0);
    cycle();
    chk("t5_busy2", 64'(bus.fpu_idle), 64'd0);
    cycle();
    chk("t5_idle",  64'(bus.fpu_idle), 64'd1);
    repeat (3) begin
      cycle();
      chk("t5_dropped", 64'(bus.start), 64'd0);
    end

    // Reset mid-stream
    bus.prf_ready = '0;
    for (int i = 0; i < 2; i++) begin
      drive_op(rand_op());
      bus.enq_val = 1'b1;
      cycle();
    end
    bus.enq_val = 1'b0;
    chk("t6_count", 64'(bus.count), 64'd2);
    reset = 1'b0;
    cycle();
    chk("t6_rcount", 64'(bus.count), 64'd0);
    chk("t6_ridle",  64'(bus.fpu_idle), 64'd1);
    reset = 1'b1;
    bus.prf_ready = '1;
    drive_op(mk_op(2, 3, 0, 1'b0, 6, 7));
    bus.enq_val = 1'b1;
    cycle();
    bus.enq_val = 1'b0;
    cycle();
    chk("t6_resume", 64'({bus.start, bus.rob_ptr_out}), 64'({1'b1, 4'd6}));
    repeat (3) cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_op(rand_op());
      bus.enq_val     = 1'($urandom);
      bus.prf_ready   = 16'($urandom | $urandom);
      bus.issue_block = ($urandom_range(0, 4) == 0);
      bus.flush       = ($urandom_range(0, 24) == 0);
      reset           = ($urandom_range(0, 59) != 0);
      cycle();
    end
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.enq_val = 1'b0;
    bus.issue_block = 1'b0;
    bus.prf_ready = '1;
    repeat (8) cycle();
    chk("drain_idle", 64'(bus.fpu_idle), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
